// File: rtl/fetch_ctrl.sv
// Fetch-stage PC sequencer: issues word-aligned imem requests, applies backend
// redirects, drops stale responses and buffers instructions for decode.
module fetch_ctrl #(
  parameter  int ADDR_WIDTH = 32,
  parameter  int DEPTH      = 4,
  localparam int W          = ADDR_WIDTH - 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] rst_addr,
  input  logic         backend_redirect_en,
  input  logic [W-1:0] backend_redirect_addr,
  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [W-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [31:0]  imem_rsp_data,
  output logic         dec_valid,
  input  logic         dec_ready,
  output logic [31:0]  dec_insn,
  output logic [W-1:0] dec_pc,
  output logic [W-1:0] fetch_addr
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  localparam logic [0:0] ST_BOOT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] outstanding, outstanding_next, drop_cnt, fifo_count;
  logic [CW:0]   in_use;

  // The PC queue holds only live (non-dropped) requests, in issue order.
  logic [W-1:0]  pcq_mem [DEPTH];
  logic [PW-1:0] pcq_wr, pcq_rd;

  logic [W-1:0]  fifo_pc   [DEPTH];
  logic [31:0]   fifo_insn [DEPTH];
  logic [PW-1:0] fifo_wr, fifo_rd;

  logic req_fire, rsp_drop, fifo_push, fifo_pop;

  assign in_use         = {1'b0, outstanding} + {1'b0, fifo_count};
  assign imem_req_valid = (state == ST_RUN) && (in_use < DEPTH_C) && !backend_redirect_en;
  assign imem_req_addr  = fetch_addr;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop  = backend_redirect_en || (drop_cnt != '0);
  assign fifo_push = imem_rsp_valid && !rsp_drop;
  assign dec_valid = (fifo_count != '0);
  assign fifo_pop  = dec_valid && dec_ready;
  assign dec_insn  = fifo_insn[fifo_rd];
  assign dec_pc    = fifo_pc[fifo_rd];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    outstanding_next = outstanding;
    case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_next = outstanding + CW'(1);
      2'b01:   outstanding_next = outstanding - CW'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      fetch_addr  <= rst_addr;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      state       <= ST_RUN;
      outstanding <= outstanding_next;
      if (req_fire) pcq_wr <= pcq_wr + PW'(1);

      if (backend_redirect_en) begin
        // Everything still in flight becomes stale, including this cycle's traffic.
        fetch_addr <= backend_redirect_addr;
        drop_cnt   <= outstanding_next;
        fifo_count <= '0;
        fifo_wr    <= '0;
        fifo_rd    <= '0;
        pcq_rd     <= pcq_wr;
      end else begin
        if (req_fire) fetch_addr <= fetch_addr + W'(1);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
        if (fifo_push) begin
          fifo_wr <= fifo_wr + PW'(1);
          pcq_rd  <= pcq_rd + PW'(1);
        end
        if (fifo_pop) fifo_rd <= fifo_rd + PW'(1);
        case ({fifo_push, fifo_pop})
          2'b10:   fifo_count <= fifo_count + CW'(1);
          2'b01:   fifo_count <= fifo_count - CW'(1);
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // NOTE: storage arrays carry no reset; the pointers and counts alone define validity.
  always_ff @(posedge clk) begin
    if (req_fire) pcq_mem[pcq_wr] <= fetch_addr;
    if (fifo_push) begin
      fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
      fifo_insn[fifo_wr] <= imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && (fifo_count == FULL_C)));

endmodule
